// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto region sequencer: register decode,
// CTRL/STATUS bit positions, FSM state encoding and the address decoder.
package crypto_pkg;

    localparam int DW_DEFAULT = 10;

    // Address bit that selects each register inside the region.
    localparam int ADDR_KEY_BIT    = 2;
    localparam int ADDR_DATA_BIT   = 3;
    localparam int ADDR_CTRL_BIT   = 4;
    localparam int ADDR_STATUS_BIT = 5;

    // Byte offsets inside the region and the bits that take part in decode.
    localparam logic [5:0] OFF_KEY       = 6'(1 << ADDR_KEY_BIT);
    localparam logic [5:0] OFF_DATA      = 6'(1 << ADDR_DATA_BIT);
    localparam logic [5:0] OFF_CTRL      = 6'(1 << ADDR_CTRL_BIT);
    localparam logic [5:0] OFF_STATUS    = 6'(1 << ADDR_STATUS_BIT);
    localparam logic [5:0] ADDR_DEC_MASK = 6'h3C;

    // CTRL register fields.
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_AUTOKEY_BIT = 1;

    // STATUS register fields.
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_KEYV_BIT = 1;
    localparam int STAT_BUSY_BIT = 2;
    localparam int STAT_ERR_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } crypto_state_e;

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_KEY    = 3'd1,
        REG_DATA   = 3'd2,
        REG_CTRL   = 3'd3,
        REG_STATUS = 3'd4
    } reg_sel_e;

    // One-hot register decode; anything other than exactly one decode bit
    // (or a deselected region) maps to no register.
    function automatic reg_sel_e decode_reg(input logic sel, input logic [5:0] addr);
        reg_sel_e r_sel;
        r_sel = REG_NONE;
        if (!sel) begin
            r_sel = REG_NONE;
        end else begin
            case (addr & ADDR_DEC_MASK)
                OFF_KEY:    r_sel = REG_KEY;
                OFF_DATA:   r_sel = REG_DATA;
                OFF_CTRL:   r_sel = REG_CTRL;
                OFF_STATUS: r_sel = REG_STATUS;
                default:    r_sel = REG_NONE;
            endcase
        end
        return r_sel;
    endfunction

endpackage

// File: rtl/crypto_ctrl.sv
// Memory-mapped sequencer between the CPU data bus and the TRNG / AES
// datapaths: fetches a key, latches plaintext, pulses the AES start,
// captures ciphertext and reports busy/done/err, with a watchdog that
// aborts a hung datapath.
module crypto_ctrl
    import crypto_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [5:0]    addr,
    input  logic          we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic [DW-1:0] trng_out,
    input  logic          trng_ready,
    output logic          aes_start,
    output logic [DW-1:0] aes_pt,
    output logic [DW-1:0] aes_key,
    input  logic [DW-1:0] aes_ct,
    input  logic          aes_ready,
    output logic          done
);

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_ZERO = {WDW{1'b0}};
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
    // The watchdog fires on the edge at which the count would reach TIMEOUT,
    // so a datapath gets exactly TIMEOUT cycles in KEYGEN or WAIT.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    crypto_state_e  r_state;
    crypto_state_e  w_next;

    logic [DW-1:0]  r_key;
    logic [DW-1:0]  r_pt;
    logic [DW-1:0]  r_ct;
    logic           r_key_valid;
    logic           r_autokey;
    logic           r_done;
    logic           r_err;
    logic           r_pending;
    logic           r_aes_start;
    logic [WDW-1:0] r_wd;

    reg_sel_e       w_reg;
    logic           w_busy;
    logic           w_wr_key;
    logic           w_wr_data;
    logic           w_wr_ctrl;
    logic           w_wr_status;
    logic           w_cfg_wr;
    logic           w_cfg_reject;
    logic           w_start_req;
    logic           w_need_key;
    logic           w_wd_expire;
    logic           w_wait_armed;
    logic           w_unused_wdata;

    // FSM output strobes
    logic           w_key_capture;
    logic           w_ct_capture;
    logic           w_trng_timeout;
    logic           w_aes_timeout;
    logic           w_pending_set;
    logic           w_wd_clear;
    logic           w_wd_run;

    assign w_reg        = decode_reg(sel, addr);
    assign w_busy       = (r_state != ST_IDLE);
    assign w_wr_key     = we && (w_reg == REG_KEY);
    assign w_wr_data    = we && (w_reg == REG_DATA);
    assign w_wr_ctrl    = we && (w_reg == REG_CTRL);
    assign w_wr_status  = we && (w_reg == REG_STATUS);
    assign w_cfg_wr     = w_wr_key || w_wr_data || w_wr_ctrl;
    assign w_cfg_reject = w_cfg_wr && w_busy;
    assign w_start_req  = w_wr_ctrl && !w_busy && wdata[CTRL_START_BIT];
    // The autokey bit of the same write decides whether this start refreshes the key.
    assign w_need_key   = wdata[CTRL_AUTOKEY_BIT] || !r_key_valid;
    assign w_wd_expire  = (r_wd >= WD_LAST);
    // The watchdog is zero only in the first cycle of WAIT; that cycle ignores aes_ready.
    assign w_wait_armed = (r_wd != WD_ZERO);

    assign w_unused_wdata = ^wdata[31:DW];

    assign aes_start = r_aes_start;
    assign aes_pt    = r_pt;
    assign aes_key   = r_key;
    assign done      = r_done;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_key) begin
                    w_next = ST_KEYGEN;
                end else if (w_start_req) begin
                    w_next = w_need_key ? ST_KEYGEN : ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_KEYGEN: begin
                if (trng_ready) begin
                    w_next = r_pending ? ST_START : ST_IDLE;
                end else if (w_wd_expire) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_KEYGEN;
                end
            end
            ST_START: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_armed && aes_ready) begin
                    w_next = ST_IDLE;
                end else if (w_wd_expire) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: capture, timeout and pending strobes
    always_comb begin
        w_key_capture  = 1'b0;
        w_ct_capture   = 1'b0;
        w_trng_timeout = 1'b0;
        w_aes_timeout  = 1'b0;
        w_pending_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_req && w_need_key) begin
                    w_pending_set = 1'b1;
                end else begin
                    w_pending_set = 1'b0;
                end
            end
            ST_KEYGEN: begin
                if (trng_ready) begin
                    w_key_capture = 1'b1;
                end else if (w_wd_expire) begin
                    w_trng_timeout = 1'b1;
                end else begin
                    w_key_capture = 1'b0;
                end
            end
            ST_START: begin
                w_key_capture = 1'b0;
            end
            ST_WAIT: begin
                if (w_wait_armed && aes_ready) begin
                    w_ct_capture = 1'b1;
                end else if (w_wd_expire) begin
                    w_aes_timeout = 1'b1;
                end else begin
                    w_ct_capture = 1'b0;
                end
            end
            default: begin
                w_key_capture = 1'b0;
            end
        endcase
    end

    assign w_wd_clear = ((w_next == ST_KEYGEN) && (r_state != ST_KEYGEN)) ||
                        ((w_next == ST_WAIT)   && (r_state != ST_WAIT));
    assign w_wd_run   = (r_state == ST_KEYGEN) || (r_state == ST_WAIT);

    // Watchdog: restarts on entry to KEYGEN/WAIT and saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wd <= WD_ZERO;
        end else if (w_wd_clear) begin
            r_wd <= WD_ZERO;
        end else if (w_wd_run && (r_wd != WD_MAX)) begin
            r_wd <= r_wd + WD_ONE;
        end else begin
            r_wd <= r_wd;
        end
    end

    // CPU-written configuration: plaintext and autokey, only accepted while idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pt      <= {DW{1'b0}};
            r_autokey <= 1'b0;
        end else begin
            if (w_wr_data && !w_busy) begin
                r_pt <= wdata[DW-1:0];
            end
            if (w_wr_ctrl && !w_busy) begin
                r_autokey <= wdata[CTRL_AUTOKEY_BIT];
            end
        end
    end

    // Key register and its validity; a TRNG timeout invalidates the old key
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_key       <= {DW{1'b0}};
            r_key_valid <= 1'b0;
        end else if (w_key_capture) begin
            r_key       <= trng_out;
            r_key_valid <= 1'b1;
        end else if (w_trng_timeout) begin
            r_key_valid <= 1'b0;
        end
    end

    // Start request remembered across KEYGEN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= 1'b0;
        end else if (w_pending_set) begin
            r_pending <= 1'b1;
        end else if ((r_state == ST_KEYGEN) && (w_next != ST_KEYGEN)) begin
            r_pending <= 1'b0;
        end
    end

    // Ciphertext capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ct <= {DW{1'b0}};
        end else if (w_ct_capture) begin
            r_ct <= aes_ct;
        end
    end

    // Sticky done: completion beats a same-edge STATUS clear; a new START clears it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (w_ct_capture) begin
            r_done <= 1'b1;
        end else if (w_next == ST_START) begin
            r_done <= 1'b0;
        end else if (w_wr_status) begin
            r_done <= 1'b0;
        end
    end

    // Sticky error: watchdog expiry or configuration write while busy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_trng_timeout || w_aes_timeout || w_cfg_reject) begin
            r_err <= 1'b1;
        end else if (w_wr_status) begin
            r_err <= 1'b0;
        end
    end

    // AES start pulse, registered so it is high exactly during the START cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_aes_start <= 1'b0;
        end else begin
            r_aes_start <= (w_next == ST_START);
        end
    end

    // Zero-latency register readback
    always_comb begin
        rdata = 32'h0000_0000;
        case (w_reg)
            REG_KEY:    rdata = {{(31 - DW){1'b0}}, r_key_valid, r_key};
            REG_DATA:   rdata = {{(32 - DW){1'b0}}, r_ct};
            REG_CTRL:   rdata = {30'b0, r_autokey, 1'b0};
            REG_STATUS: rdata = {28'b0, r_err, w_busy, r_key_valid, r_done};
            default:    rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_crypto_ctrl.sv
// Directed self-checking bench for crypto_ctrl (watchdog shortened to 16).
module tb_crypto_ctrl;

    localparam int DW = 10;
    localparam logic [5:0] A_KEY    = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_CTRL   = 6'h10;
    localparam logic [5:0] A_STATUS = 6'h20;

    logic          clk;
    logic          reset;
    logic          sel;
    logic [5:0]    addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [DW-1:0] trng_out;
    logic          trng_ready;
    logic          aes_start;
    logic [DW-1:0] aes_pt;
    logic [DW-1:0] aes_key;
    logic [DW-1:0] aes_ct;
    logic          aes_ready;
    logic          done;

    int n_checks;
    int n_errors;
    int start_cnt;

    crypto_ctrl #(.DW(DW), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .trng_out   (trng_out),
        .trng_ready (trng_ready),
        .aes_start  (aes_start),
        .aes_pt     (aes_pt),
        .aes_key    (aes_key),
        .aes_ct     (aes_ct),
        .aes_ready  (aes_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count start pulses mid-cycle
    always @(negedge clk) begin
        if (aes_start) start_cnt <= start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        sel  = 1'b1;
        addr = a;
        we   = 1'b0;
        #1;
        check_eq(tag, rdata, exp);
        sel  = 1'b0;
        addr = 6'h00;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        sel   = 1'b1;
        addr  = a;
        we    = 1'b1;
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 6'h00;
        wdata = 32'h0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; start_cnt = 0;
        reset = 1'b0; sel = 1'b0; addr = 6'h00; we = 1'b0; wdata = 32'h0;
        trng_out = '0; trng_ready = 1'b0; aes_ct = '0; aes_ready = 1'b0;

        // reset state
        tick(); tick();
        check_eq("rst_aes_start", 32'(aes_start), 32'h0);
        check_eq("rst_aes_pt", 32'(aes_pt), 32'h0);
        check_eq("rst_aes_key", 32'(aes_key), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        chk_rd("rst_status", A_STATUS, 32'h0);
        chk_rd("rst_key", A_KEY, 32'h0);
        chk_rd("rst_data", A_DATA, 32'h0);
        chk_rd("rst_ctrl", A_CTRL, 32'h0);
        reset = 1'b1;
        tick();

        // A: start without key -> KEYGEN, TRNG in 3rd cycle, AES in WAIT cycle 3
        wr(A_DATA, 32'h2A5);
        wr(A_CTRL, 32'h1);
        chk_rd("a_status_keygen", A_STATUS, 32'h4);
        tick(); tick();
        trng_out = 10'h155; trng_ready = 1'b1;
        tick();
        check_eq("a_start_pulse", 32'(aes_start), 32'h1);
        check_eq("a_start_pt", 32'(aes_pt), 32'h2A5);
        check_eq("a_start_key", 32'(aes_key), 32'h155);
        trng_ready = 1'b0; trng_out = '0;
        tick(); tick(); tick();
        aes_ct = 10'h3C3; aes_ready = 1'b1;
        check_eq("a_done_before", 32'(done), 32'h0);
        tick();
        aes_ready = 1'b0;
        check_eq("a_done_after", 32'(done), 32'h1);
        chk_rd("a_data_ct", A_DATA, 32'h3C3);
        chk_rd("a_status", A_STATUS, 32'h3);
        chk_rd("a_key_read", A_KEY, 32'h555);
        check_eq("a_start_cnt", 32'(start_cnt), 32'd1);

        // B: direct start, busy CTRL write rejected, aes_ready high during START
        wr(A_CTRL, 32'h1);
        check_eq("b_start_pulse", 32'(aes_start), 32'h1);
        check_eq("b_done_cleared", 32'(done), 32'h0);
        aes_ct = 10'h0F0; aes_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        chk_rd("b_status_err_busy", A_STATUS, 32'hE);
        tick();
        chk_rd("b_first_wait_ignored", A_DATA, 32'h3C3);
        tick();
        aes_ready = 1'b0;
        chk_rd("b_status_done", A_STATUS, 32'hB);
        chk_rd("b_data_ct", A_DATA, 32'h0F0);
        check_eq("b_start_cnt", 32'(start_cnt), 32'd2);
        wr(A_STATUS, 32'h0);
        chk_rd("b_status_clear", A_STATUS, 32'h2);

        // C: AES never ready -> watchdog after 16 WAIT cycles
        wr(A_CTRL, 32'h1);
        tick();
        repeat (15) tick();
        chk_rd("c_wait16_busy", A_STATUS, 32'h6);
        tick();
        chk_rd("c_timeout_status", A_STATUS, 32'hA);
        check_eq("c_start_cnt", 32'(start_cnt), 32'd3);
        wr(A_STATUS, 32'h0);
        chk_rd("c_status_clear", A_STATUS, 32'h2);

        // D: autokey, two back-to-back encrypts with 1-cycle KEYGEN
        wr(A_DATA, 32'h111);
        trng_out = 10'h0AA; trng_ready = 1'b1;
        wr(A_CTRL, 32'h3);
        chk_rd("d_ctrl_read", A_CTRL, 32'h2);
        chk_rd("d_status_keygen", A_STATUS, 32'h6);
        tick();
        check_eq("d1_start_pulse", 32'(aes_start), 32'h1);
        check_eq("d1_key", 32'(aes_key), 32'h0AA);
        check_eq("d1_pt", 32'(aes_pt), 32'h111);
        trng_out = 10'h1CC;
        tick(); tick();
        aes_ct = 10'h321; aes_ready = 1'b1;
        tick();
        aes_ready = 1'b0;
        chk_rd("d1_data_ct", A_DATA, 32'h321);
        check_eq("d1_done", 32'(done), 32'h1);
        wr(A_CTRL, 32'h3);
        check_eq("d2_done_in_keygen", 32'(done), 32'h1);
        tick();
        check_eq("d2_start_pulse", 32'(aes_start), 32'h1);
        check_eq("d2_key", 32'(aes_key), 32'h1CC);
        check_eq("d2_done_cleared", 32'(done), 32'h0);
        trng_ready = 1'b0;
        tick(); tick();
        aes_ct = 10'h2B4; aes_ready = 1'b1;
        wr(A_STATUS, 32'h0);
        aes_ready = 1'b0;
        check_eq("d2_done_wins", 32'(done), 32'h1);
        chk_rd("d2_status", A_STATUS, 32'h3);
        chk_rd("d2_data_ct", A_DATA, 32'h2B4);
        check_eq("d_start_cnt", 32'(start_cnt), 32'd5);

        // E: KEY write with TRNG silent -> timeout clears key_valid
        wr(A_KEY, 32'h0);
        repeat (15) tick();
        chk_rd("e_keygen16_busy", A_STATUS, 32'h7);
        tick();
        chk_rd("e_timeout_status", A_STATUS, 32'h9);
        chk_rd("e_key_kept", A_KEY, 32'h1CC);
        wr(A_STATUS, 32'h0);
        chk_rd("e_status_clear", A_STATUS, 32'h0);

        // F: multi-bit / deselected decode
        chk_rd("f_multi_read", 6'h30, 32'h0);
        addr = A_CTRL; sel = 1'b0; #1;
        check_eq("f_nosel_read", rdata, 32'h0);
        addr = 6'h00;
        wr(6'h14, 32'h1);
        chk_rd("f_multi_write", A_STATUS, 32'h0);

        // G: reset held 2 cycles mid-WAIT aborts the operation
        wr(A_DATA, 32'h155);
        trng_out = 10'h3FF; trng_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        tick();
        trng_ready = 1'b0;
        check_eq("g_start_pulse", 32'(aes_start), 32'h1);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check_eq("g_rst_aes_start", 32'(aes_start), 32'h0);
        check_eq("g_rst_pt", 32'(aes_pt), 32'h0);
        check_eq("g_rst_key", 32'(aes_key), 32'h0);
        chk_rd("g_rst_status", A_STATUS, 32'h0);
        chk_rd("g_rst_data", A_DATA, 32'h0);
        reset = 1'b1;
        aes_ready = 1'b1;
        repeat (5) tick();
        aes_ready = 1'b0;
        check_eq("g_no_start_after", 32'(start_cnt), 32'd6);
        chk_rd("g_idle_after", A_STATUS, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crypto_ctrl.md
# crypto_ctrl

Memory-mapped sequencer for the crypto region (address bit 9, base 0x0000_0200) that sits between the pipelined CPU's data bus and the `trng` and `aes10` datapaths. It fetches a 10-bit key from the TRNG, latches a CPU-written plaintext, drives a single-cycle start to the AES core and captures the ciphertext. It exposes busy/done/error status so software can poll instead of decoding raw `trng_ready`/`aes_ready`. A watchdog keeps a hung datapath from locking the bus.

## Interface
Parameters:
- `DW`, 10, data width of key, plaintext and ciphertext
- `TIMEOUT`, 1024, max cycles spent waiting on either datapath before error

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `sel`  in  1  crypto region selected (addr[9])
- `addr`  in  6  byte address bits [5:0]; bits 2..5 decode registers
- `we`  in  1  CPU store strobe
- `wdata`  in  32  store data
- `rdata`  out  32  load data, combinational from `addr`
- `trng_out`  in  DW  TRNG sample
- `trng_ready`  in  1  TRNG sample valid (level)
- `aes_start`  out  1  one-cycle start pulse to AES
- `aes_pt`  out  DW  plaintext to AES, stable from start until capture
- `aes_key`  out  DW  key to AES, stable from start until capture
- `aes_ct`  in  DW  AES ciphertext
- `aes_ready`  in  1  AES result valid (level)
- `done`  out  1  sticky completion flag (LED-drivable)

## Operation
- Register map (one-hot decode, `sel` required): bit2 0x204 KEY; bit3 0x208 DATA; bit4 0x210 CTRL; bit5 0x220 STATUS.
- KEY write: request new key (enters KEYGEN if IDLE). KEY read: {21'b0, key_valid, key}.
- DATA write: latch wdata[DW-1:0] as plaintext. DATA read: {22'b0, ciphertext}.
- CTRL write: bit0 = start, bit1 = autokey (fetch fresh key before this encrypt). Read: {30'b0, autokey, 0}.
- STATUS read: {28'b0, err, busy, key_valid, done}. STATUS write (any data): clears `done` and `err`.
- Unmapped or multiple-bit addresses read 0; writes ignored.
- FSM states: IDLE, KEYGEN, START, WAIT.
  - IDLE -> KEYGEN on KEY write, or start with autokey=1 or key_valid=0 (start remembered as pending).
  - IDLE -> START on start with key_valid=1 and autokey=0.
  - KEYGEN: first cycle with `trng_ready`=1 captures `trng_out` into key, sets key_valid; -> START if start pending, else IDLE.
  - START: `aes_start`=1 for exactly this cycle; -> WAIT.
  - WAIT: ignores `aes_ready` on its first cycle; after that, first cycle with `aes_ready`=1 captures `aes_ct`, sets `done`, -> IDLE.
- Watchdog: counter cleared on entering KEYGEN/WAIT; reaching TIMEOUT sets `err`, clears pending start, -> IDLE; key_valid unchanged on AES timeout, cleared on TRNG timeout.
- busy = state != IDLE.
- Writes to KEY, DATA or CTRL while busy are ignored and set `err`; STATUS writes always accepted.
- Start with `done` already set: allowed; `done` cleared at START.

## Timing
- Reset (reset=0 at a clock edge): state IDLE, `aes_start`=0, `aes_pt`=0, `aes_key`=0, `done`=0, err=0, key_valid=0, autokey=0, ciphertext=0, watchdog=0. Reset mid-operation aborts immediately; no start pulse issued afterward.
- Start write at edge N with key valid, autokey=0: `aes_start` high in cycle N+1, WAIT from N+2.
- `trng_ready` already high when KEYGEN entered: key captured in the first KEYGEN cycle (1-cycle KEYGEN).
- `aes_ready` high at WAIT cycle k>=2: ciphertext and `done` visible the cycle after that edge.
- Simultaneous STATUS-clear and completion on the same edge: completion wins (`done`=1).
- Watchdog width ceil(log2(TIMEOUT+1)); no wrap, saturates at TIMEOUT.
- `rdata` has zero latency; reflects register contents before the current edge.

## Structure
- Package `crypto_pkg`: register offsets/bit indices (KEY=2, DATA=3, CTRL=4, STATUS=5), STATUS/CTRL bit positions, FSM state enum, DW default.
- Single module; watchdog counter inline. No sub-module needed.

## Test plan
- Reset low 2 cycles mid-WAIT -> all outputs 0, state IDLE, no further `aes_start`.
- Write DATA=0x2A5, CTRL=0x1 with key_valid=0; TRNG gives 0x155 after 3 cycles -> key=0x155, one `aes_start` pulse with pt=0x2A5, key=0x155; AES ready 5 cycles later with ct=0x3C3 -> DATA reads 0x3C3, STATUS=0b0011.
- Write CTRL=0x1 while busy -> request ignored, single start pulse total, STATUS err=1; STATUS write -> err=0.
- `aes_ready` held high during START -> ignored in first WAIT cycle, captured on second; exactly one capture.
- TIMEOUT=16, `aes_ready` never asserted -> after 16 WAIT cycles err=1, busy=0, key_valid still 1.
- autokey=1, two back-to-back encrypts -> two KEYGEN passes, distinct captured keys, `done` cleared at second START.
